// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data-path widths used by the execute stage,
// ex_mem_reg and the MEM stage, plus the MEM/WB control bundle.
package pipeline_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_WIDTH  = 5;
  localparam int JUMP_WIDTH = 11;

  // Write-back control bits carried through the MEM/WB register.
  typedef struct packed {
    logic reg_write;   // write-back enable
    logic mem_to_reg;  // 1 = write back the loaded word, 0 = the ALU result
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_CTRL_NOP = '{reg_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/memory_stage_if.sv
// Signal bundle between the EX/MEM register, the MEM stage and its
// consumers (IF for branch redirect, WB for the MEM/WB fields).
interface memory_stage_if;
  import pipeline_pkg::*;

  // EX/MEM side
  logic [DATA_WIDTH-1:0] result_in;
  logic [DATA_WIDTH-1:0] registro_2_in;
  logic [REG_WIDTH-1:0]  reg_dest_in;
  logic [JUMP_WIDTH-1:0] jump_dest_addr_in;
  logic                  zero_signal_in;
  logic                  Branch;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  RegWrite;
  logic                  MemtoReg;

  // IF / WB side
  logic                  pc_src;
  logic [JUMP_WIDTH-1:0] jump_dest_addr_out;
  logic [DATA_WIDTH-1:0] read_data_out;
  logic [DATA_WIDTH-1:0] alu_result_out;
  logic [REG_WIDTH-1:0]  reg_dest_out;
  logic                  RegWrite_out;
  logic                  MemtoReg_out;
  logic                  mem_fault;

  // Drives the stage inputs and observes its outputs.
  modport master (
    output result_in, registro_2_in, reg_dest_in, jump_dest_addr_in,
           zero_signal_in, Branch, MemRead, MemWrite, RegWrite, MemtoReg,
    input  pc_src, jump_dest_addr_out, read_data_out, alu_result_out,
           reg_dest_out, RegWrite_out, MemtoReg_out, mem_fault
  );

  // The MEM stage itself.
  modport slave (
    input  result_in, registro_2_in, reg_dest_in, jump_dest_addr_in,
           zero_signal_in, Branch, MemRead, MemWrite, RegWrite, MemtoReg,
    output pc_src, jump_dest_addr_out, read_data_out, alu_result_out,
           reg_dest_out, RegWrite_out, MemtoReg_out, mem_fault
  );

endinterface

// File: rtl/data_memory.sv
// Single-port data RAM: synchronous write, read-first synchronous read.
// A cycle without a read enable registers zero on rdata.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port share one edge.
  // NOTE: the array has no reset so it maps onto block RAM; contents survive
  // a pipeline reset. Both assignments are non-blocking, so a read and a
  // write to the same word in one cycle returns the old word (read-first).
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register for the non-memory fields: ALU result,
// destination register and write-back control bundle.
module mem_wb_reg
  import pipeline_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [REG_WIDTH-1:0]  reg_dest_in,
  input  wb_ctrl_t              ctrl_in,
  output logic [DATA_WIDTH-1:0] alu_result_out,
  output logic [REG_WIDTH-1:0]  reg_dest_out,
  output wb_ctrl_t              ctrl_out
);

  // Capture one instruction per cycle; synchronous reset flushes the entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_result_out <= '0;
      reg_dest_out   <= '0;
      ctrl_out       <= WB_CTRL_NOP;
    end else begin
      alu_result_out <= alu_result_in;
      reg_dest_out   <= reg_dest_in;
      ctrl_out       <= ctrl_in;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: branch resolution, data-memory access and the MEM/WB register.
// A load result appears one cycle after the stage inputs, aligned with the
// rest of the MEM/WB fields.
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input logic            clock,
  input logic            reset,
  memory_stage_if.slave  bus
);

  logic                 misaligned;
  logic                 mem_we;
  logic                 mem_re;
  logic [ADDR_BITS-1:0] word_index;
  wb_ctrl_t             ctrl_in;
  wb_ctrl_t             ctrl_out;
  logic                 fault_q;

  // Upper address bits are deliberately ignored: addresses wrap modulo
  // 4 * depth bytes.
  logic unused_upper_addr;
  assign unused_upper_addr = &{1'b0, bus.result_in[DATA_WIDTH-1:ADDR_BITS+2]};

  // Branch decision and target go straight back to IF with no latency.
  assign bus.pc_src             = bus.Branch & bus.zero_signal_in;
  assign bus.jump_dest_addr_out = bus.jump_dest_addr_in;

  // Word addressing; any access with non-zero byte offset is a fault.
  assign word_index = bus.result_in[ADDR_BITS+1:2];
  assign misaligned = (bus.MemRead | bus.MemWrite) & (bus.result_in[1:0] != 2'b00);

  // Reset and misalignment suppress the access; a suppressed read registers 0.
  assign mem_we = bus.MemWrite & ~misaligned & ~reset;
  assign mem_re = bus.MemRead  & ~misaligned & ~reset;

  // A faulting access must not write back.
  assign ctrl_in = '{reg_write: bus.RegWrite & ~misaligned, mem_to_reg: bus.MemtoReg};

  data_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_data_memory (
    .clock (clock),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (word_index),
    .wdata (bus.registro_2_in),
    .rdata (bus.read_data_out)
  );

  mem_wb_reg u_mem_wb_reg (
    .clock          (clock),
    .reset          (reset),
    .alu_result_in  (bus.result_in),
    .reg_dest_in    (bus.reg_dest_in),
    .ctrl_in        (ctrl_in),
    .alu_result_out (bus.alu_result_out),
    .reg_dest_out   (bus.reg_dest_out),
    .ctrl_out       (ctrl_out)
  );

  assign bus.RegWrite_out = ctrl_out.reg_write;
  assign bus.MemtoReg_out = ctrl_out.mem_to_reg;

  // Sticky fault flag: set by any misaligned access, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (misaligned) begin
      fault_q <= 1'b1;
    end
  end

  assign bus.mem_fault = fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: hand-computed expectations for pass-through,
// store/load, aliasing, read-first, misalignment, branch and reset behaviour.
module tb_memory_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  memory_stage_if bus ();

  memory_stage #(.ADDR_BITS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.result_in         = '0;
    bus.registro_2_in     = '0;
    bus.reg_dest_in       = '0;
    bus.jump_dest_addr_in = '0;
    bus.zero_signal_in    = 1'b0;
    bus.Branch            = 1'b0;
    bus.MemRead           = 1'b0;
    bus.MemWrite          = 1'b0;
    bus.RegWrite          = 1'b0;
    bus.MemtoReg          = 1'b0;
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    idle();
    bus.MemWrite      = 1'b1;
    bus.result_in     = addr;
    bus.registro_2_in = data;
    tick();
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rd);
    idle();
    bus.MemRead     = 1'b1;
    bus.RegWrite    = 1'b1;
    bus.MemtoReg    = 1'b1;
    bus.result_in   = addr;
    bus.reg_dest_in = rd;
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_read", bus.read_data_out, 32'h0);
    check("rst_alu", bus.alu_result_out, 32'h0);
    check("rst_rd", {27'b0, bus.reg_dest_out}, 32'h0);
    check("rst_rw", {31'b0, bus.RegWrite_out}, 32'h0);
    check("rst_m2r", {31'b0, bus.MemtoReg_out}, 32'h0);
    check("rst_fault", {31'b0, bus.mem_fault}, 32'h0);
    reset = 1'b0;

    // R-type pass-through; 0x55 has non-zero low bits but no memory access
    idle();
    bus.result_in   = 32'h55;
    bus.reg_dest_in = 5'd7;
    bus.RegWrite    = 1'b1;
    bus.MemtoReg    = 1'b0;
    tick();
    check("rtype_alu", bus.alu_result_out, 32'h55);
    check("rtype_rd", {27'b0, bus.reg_dest_out}, 32'd7);
    check("rtype_rw", {31'b0, bus.RegWrite_out}, 32'h1);
    check("rtype_m2r", {31'b0, bus.MemtoReg_out}, 32'h0);
    check("rtype_read", bus.read_data_out, 32'h0);
    check("rtype_fault", {31'b0, bus.mem_fault}, 32'h0);

    // Store then load
    store(32'h10, 32'hDEADBEEF);
    check("store_rw", {31'b0, bus.RegWrite_out}, 32'h0);
    load(32'h10, 5'd9);
    check("ld_read", bus.read_data_out, 32'hDEADBEEF);
    check("ld_rw", {31'b0, bus.RegWrite_out}, 32'h1);
    check("ld_m2r", {31'b0, bus.MemtoReg_out}, 32'h1);
    check("ld_rd", {27'b0, bus.reg_dest_out}, 32'd9);

    // Wrap-around: byte 0x404 aliases word 1
    store(32'h0000_0404, 32'h1234);
    load(32'h4, 5'd1);
    check("wrap_read", bus.read_data_out, 32'h1234);

    // Read-first on simultaneous read and write
    idle();
    bus.MemRead       = 1'b1;
    bus.MemWrite      = 1'b1;
    bus.result_in     = 32'h10;
    bus.registro_2_in = 32'h1111_1111;
    tick();
    check("rf_old", bus.read_data_out, 32'hDEADBEEF);
    load(32'h10, 5'd2);
    check("rf_new", bus.read_data_out, 32'h1111_1111);

    // Idle cycle clears read data
    idle();
    tick();
    check("idle_read", bus.read_data_out, 32'h0);

    // Branch outputs are combinational
    idle();
    bus.Branch            = 1'b1;
    bus.zero_signal_in    = 1'b1;
    bus.jump_dest_addr_in = 11'h2A;
    #1;
    check("br_taken", {31'b0, bus.pc_src}, 32'h1);
    check("br_dest", {21'b0, bus.jump_dest_addr_out}, 32'h2A);
    bus.zero_signal_in = 1'b0;
    #1;
    check("br_nz", {31'b0, bus.pc_src}, 32'h0);
    bus.Branch         = 1'b0;
    bus.zero_signal_in = 1'b1;
    #1;
    check("br_nobr", {31'b0, bus.pc_src}, 32'h0);

    // Reference value for the reset-drop test
    store(32'h20, 32'hAAAA_5555);

    // Misaligned load
    load(32'h13, 5'd4);
    check("mis_read", bus.read_data_out, 32'h0);
    check("mis_rw", {31'b0, bus.RegWrite_out}, 32'h0);
    check("mis_fault", {31'b0, bus.mem_fault}, 32'h1);

    // Misaligned store to word 1 is suppressed; fault stays sticky
    store(32'h6, 32'h0BAD_0BAD);
    load(32'h4, 5'd5);
    check("mis_st_read", bus.read_data_out, 32'h1234);
    check("mis_st_rw", {31'b0, bus.RegWrite_out}, 32'h1);
    check("fault_sticky", {31'b0, bus.mem_fault}, 32'h1);

    // Load in flight, then reset with a store presented
    load(32'h20, 5'd3);
    check("pre_rst_read", bus.read_data_out, 32'hAAAA_5555);
    idle();
    reset             = 1'b1;
    bus.MemWrite      = 1'b1;
    bus.RegWrite      = 1'b1;
    bus.MemtoReg      = 1'b1;
    bus.result_in     = 32'h20;
    bus.reg_dest_in   = 5'd6;
    bus.registro_2_in = 32'hBBBB_BBBB;
    tick();
    check("mid_rst_read", bus.read_data_out, 32'h0);
    check("mid_rst_alu", bus.alu_result_out, 32'h0);
    check("mid_rst_rd", {27'b0, bus.reg_dest_out}, 32'h0);
    check("mid_rst_rw", {31'b0, bus.RegWrite_out}, 32'h0);
    check("mid_rst_m2r", {31'b0, bus.MemtoReg_out}, 32'h0);
    check("mid_rst_fault", {31'b0, bus.mem_fault}, 32'h0);
    reset = 1'b0;

    // First post-reset instruction registers normally; dropped store left old data
    load(32'h20, 5'd8);
    check("post_rst_read", bus.read_data_out, 32'hAAAA_5555);
    check("post_rst_alu", bus.alu_result_out, 32'h20);
    check("post_rst_rd", {27'b0, bus.reg_dest_out}, 32'd8);
    check("post_rst_rw", {31'b0, bus.RegWrite_out}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the execute stage's EX/MEM register.
- Consumes the EX/MEM outputs: ALU result, second register operand, destination register, branch target and zero flag.
- Resolves the branch decision, performs the data-memory load or store, and drives the MEM/WB register consumed by write-back.
- Contains a synchronous-read data RAM plus the MEM/WB register, so a load result appears exactly one cycle after the stage input.

Parameters:
- DATA_WIDTH, 32, data-path and memory word width
- ADDR_BITS, 8, word-address bits; depth = 2**ADDR_BITS words (256)
- JUMP_WIDTH, 11, width of branch target address
- REG_WIDTH, 5, register-file index width

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- result_in  in  DATA_WIDTH  ALU result from EX/MEM; byte address for loads and stores
- registro_2_in  in  DATA_WIDTH  store data
- reg_dest_in  in  REG_WIDTH  destination register
- jump_dest_addr_in  in  JUMP_WIDTH  branch target
- zero_signal_in  in  1  ALU zero flag
- Branch  in  1  branch-instruction control bit
- MemRead  in  1  load control bit
- MemWrite  in  1  store control bit
- RegWrite  in  1  write-back enable control bit
- MemtoReg  in  1  write-back source select (1 = memory)
- pc_src  out  1  branch taken, to IF stage (combinational)
- jump_dest_addr_out  out  JUMP_WIDTH  branch target to IF (combinational pass-through)
- read_data_out  out  DATA_WIDTH  MEM/WB: loaded word
- alu_result_out  out  DATA_WIDTH  MEM/WB: registered result_in
- reg_dest_out  out  REG_WIDTH  MEM/WB: registered reg_dest_in
- RegWrite_out  out  1  MEM/WB: registered, possibly suppressed RegWrite
- MemtoReg_out  out  1  MEM/WB: registered MemtoReg
- mem_fault  out  1  sticky misaligned-access flag

Behaviour:
- Combinational branch outputs:
  - pc_src = Branch & zero_signal_in.
  - jump_dest_addr_out = jump_dest_addr_in.
  - Both have zero latency and are unaffected by reset.
- Address decoding:
  - Word index = result_in[ADDR_BITS+1:2].
  - Upper bits are ignored, so addresses wrap modulo 4*depth bytes.
  - misaligned = (MemRead | MemWrite) & (result_in[1:0] != 0).
- Store:
  - On a rising edge with MemWrite & ~misaligned & ~reset, mem[index] <= registro_2_in.
  - Stored data is visible to a load issued on the following cycle.
- Load:
  - The RAM is read synchronously. On the rising edge with MemRead, read_data_out <= mem[index].
  - Latency is 1 cycle, aligned with the other MEM/WB fields.
  - A misaligned load registers read_data_out = 0.
- MemRead and MemWrite both high: the write is performed and read_data_out returns the pre-write contents (read-first).
- No memory access (MemRead = 0): read_data_out <= 0.
- MEM/WB register, every non-reset edge:
  - alu_result_out <= result_in
  - reg_dest_out <= reg_dest_in
  - MemtoReg_out <= MemtoReg
  - RegWrite_out <= RegWrite & ~misaligned
- mem_fault:
  - Set on any edge with misaligned.
  - Cleared only by reset.
  - Stays set through subsequent good accesses.
- Reset (synchronous):
  - read_data_out, alu_result_out, reg_dest_out, RegWrite_out, MemtoReg_out and mem_fault all go to 0.
  - A store presented in the reset cycle is dropped.
  - RAM contents are not cleared.
  - Reset asserted mid-stream flushes the in-flight MEM/WB entry. The first post-reset instruction is registered normally on the first edge with reset low.
- No stall or back-pressure; one instruction is accepted per cycle.

Decomposition:
- Shared package, pipeline_pkg, holds:
  - width constants DATA_WIDTH, REG_WIDTH and JUMP_WIDTH, shared with the execute stage and ex_mem_reg.
  - the MEM/WB control-bundle field definitions (RegWrite, MemtoReg).
- Sub-modules:
  - data_memory: single-port RAM with synchronous write and read-first synchronous read; ports clock, we, re, addr, wdata, rdata.
  - mem_wb_reg: MEM/WB register, in the same style as ex_mem_reg.
  - memory_stage: instantiates both and adds the branch, misalign and fault logic.

Test Plan:
- Store then load:
  - Cycle 0: MemWrite, result_in = 0x10, registro_2_in = 0xDEADBEEF.
  - Cycle 1: MemRead, result_in = 0x10, RegWrite = 1, MemtoReg = 1.
  - Required: after edge 2, read_data_out = 0xDEADBEEF and RegWrite_out = 1.
- Wrap-around: store 0x1234 at result_in = 0x0000_0404, then load 0x4. Required: read_data_out = 0x1234, because index 1 aliases modulo 1 KiB.
- Misaligned load: MemRead, result_in = 0x13, RegWrite = 1. Required: read_data_out = 0, RegWrite_out = 0, mem_fault = 1, and mem_fault stays 1 after a later aligned load.
- Branch:
  - Branch = 1, zero_signal_in = 1, jump_dest_addr_in = 0x2A: pc_src = 1 and jump_dest_addr_out = 0x2A in the same cycle.
  - zero_signal_in = 0: pc_src = 0.
- Reset mid-stream:
  - Reset asserted while a load is in flight: all MEM/WB outputs and mem_fault = 0 after the edge.
  - Store presented during reset: a later load from that address returns the old value.
- R-type pass-through: result_in = 0x55, reg_dest_in = 7, RegWrite = 1, MemtoReg = 0. Required after 1 cycle: alu_result_out = 0x55, reg_dest_out = 7, RegWrite_out = 1, read_data_out = 0.
